// File: rtl/phyip_reset_responder.sv
// Transceiver PHY stand-in answering the reset controller (cal busy, CDR lock, ready).
// Optional lock-loss counter on los_count is enabled by defining PHYIP_RESP_LOSCNT_EN.
module phyip_reset_responder #(
   parameter int TX_CAL_CYCLES   = 200,
   parameter int RX_CAL_CYCLES   = 150,
   parameter int CDR_LOCK_CYCLES = 64,
   parameter int CNT_W           = 16
) (
   input  logic       clk,
   input  logic       tx_analogreset,
   input  logic       rx_analogreset,
   input  logic       tx_digitalreset,
   input  logic       rx_digitalreset,
   input  logic       rx_signal_detect,
   output logic       tx_cal_busy,
   output logic       rx_cal_busy,
   output logic       rx_is_lockedtodata,
   output logic       tx_phy_ready,
   output logic       rx_phy_ready,
   output logic [1:0] seq_error,
   output logic [7:0] los_count
);

   typedef enum logic [1:0] {
      T_CAL  = 2'd0,
      T_WAIT = 2'd1,
      T_RUN  = 2'd2
   } tx_state_t;

   typedef enum logic [1:0] {
      R_CAL  = 2'd0,
      R_CDR  = 2'd1,
      R_LOCK = 2'd2,
      R_RUN  = 2'd3
   } rx_state_t;

   localparam logic [CNT_W-1:0] TX_LOAD  = CNT_W'(TX_CAL_CYCLES);
   localparam logic [CNT_W-1:0] RX_LOAD  = CNT_W'(RX_CAL_CYCLES);
   localparam logic [CNT_W-1:0] LOCK_END = CNT_W'(CDR_LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   tx_state_t        tx_st, tx_nxt;
   rx_state_t        rx_st, rx_nxt;
   logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
   logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
   logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
   logic             tx_dr_prev, rx_dr_prev;
   logic             tx_fall, rx_fall;

   always_ff @(posedge clk or posedge tx_analogreset) begin
      if (tx_analogreset) begin
         tx_st      <= T_CAL;
         tx_cnt     <= TX_LOAD;
         rx_st      <= R_CAL;
         rx_cnt     <= RX_LOAD;
         lock_cnt   <= '0;
         tx_dr_prev <= 1'b1;
         rx_dr_prev <= 1'b1;
      end else begin
         tx_st      <= tx_nxt;
         tx_cnt     <= tx_cnt_nxt;
         rx_st      <= rx_nxt;
         rx_cnt     <= rx_cnt_nxt;
         lock_cnt   <= lock_cnt_nxt;
         tx_dr_prev <= tx_digitalreset;
         rx_dr_prev <= rx_digitalreset;
      end
   end

   always_comb begin
      tx_nxt     = tx_st;
      tx_cnt_nxt = tx_cnt;
      unique case (tx_st)
         T_CAL: begin
            if (tx_cnt != '0) tx_cnt_nxt = tx_cnt - ONE;
            if (tx_cnt <= ONE) tx_nxt = T_WAIT;
         end
         T_WAIT: if (!tx_digitalreset) tx_nxt = T_RUN;
         T_RUN:  if (tx_digitalreset) tx_nxt = T_WAIT;
         default: tx_nxt = T_CAL;
      endcase
   end

   // Lock loss outranks digital-reset moves; rx_analogreset outranks everything.
   always_comb begin
      rx_nxt       = rx_st;
      rx_cnt_nxt   = rx_cnt;
      lock_cnt_nxt = lock_cnt;
      if (rx_analogreset) begin
         rx_nxt       = R_CAL;
         rx_cnt_nxt   = RX_LOAD;
         lock_cnt_nxt = '0;
      end else begin
         unique case (rx_st)
            R_CAL: begin
               if (rx_cnt != '0) rx_cnt_nxt = rx_cnt - ONE;
               if (rx_cnt <= ONE) begin
                  rx_nxt       = R_CDR;
                  lock_cnt_nxt = '0;
               end
            end
            R_CDR: begin
               if (!rx_signal_detect) lock_cnt_nxt = '0;
               else if (lock_cnt >= LOCK_END) rx_nxt = R_LOCK;
               else lock_cnt_nxt = lock_cnt + ONE;
            end
            R_LOCK: begin
               if (!rx_signal_detect) begin
                  rx_nxt       = R_CDR;
                  lock_cnt_nxt = '0;
               end else if (!rx_digitalreset) begin
                  rx_nxt = R_RUN;
               end
            end
            R_RUN: begin
               if (!rx_signal_detect) begin
                  rx_nxt       = R_CDR;
                  lock_cnt_nxt = '0;
               end else if (rx_digitalreset) begin
                  rx_nxt = R_LOCK;
               end
            end
            default: rx_nxt = R_CAL;
         endcase
      end
   end

   assign tx_fall = tx_dr_prev & ~tx_digitalreset;
   assign rx_fall = rx_dr_prev & ~rx_digitalreset;

   always_ff @(posedge clk or posedge tx_analogreset) begin
      if (tx_analogreset) begin
         seq_error <= 2'b00;
      end else begin
         if (tx_fall && tx_st == T_CAL)
            seq_error[0] <= 1'b1;
         if (rx_fall && (rx_st == R_CAL || rx_st == R_CDR))
            seq_error[1] <= 1'b1;
      end
   end

   assign tx_cal_busy        = (tx_st == T_CAL);
   assign tx_phy_ready       = (tx_st == T_RUN);
   assign rx_cal_busy        = (rx_st == R_CAL);
   assign rx_is_lockedtodata = (rx_st == R_LOCK) || (rx_st == R_RUN);
   assign rx_phy_ready       = (rx_st == R_RUN);

`ifdef PHYIP_RESP_LOSCNT_EN
   logic       los_evt;
   logic [7:0] los_q;

   assign los_evt = ~rx_analogreset & ~rx_signal_detect &
                    ((rx_st == R_LOCK) || (rx_st == R_RUN));

   always_ff @(posedge clk or posedge tx_analogreset) begin
      if (tx_analogreset)
         los_q <= 8'd0;
      else if (los_evt && los_q != 8'hFF)
         los_q <= los_q + 8'd1;
   end

   assign los_count = los_q;
`else
   assign los_count = 8'd0;
`endif

endmodule

// File: tb/tb_phyip_reset_responder.sv
// Scoreboard bench for phyip_reset_responder with short timings.
// Expectations queued with a target cycle; negedge monitor compares.
module tb_phyip_reset_responder;

  logic       clk = 1'b0;
  logic       tx_analogreset = 1'b1;
  logic       rx_analogreset = 1'b0;
  logic       tx_digitalreset = 1'b1;
  logic       rx_digitalreset = 1'b1;
  logic       rx_signal_detect = 1'b1;
  logic       tx_cal_busy, rx_cal_busy, rx_is_lockedtodata;
  logic       tx_phy_ready, rx_phy_ready;
  logic [1:0] seq_error;
  logic [7:0] los_count;

`ifdef PHYIP_RESP_LOSCNT_EN
  localparam int LOS_EN = 1;
`else
  localparam int LOS_EN = 0;
`endif

  localparam logic [14:0] TXB = 15'h4000;
  localparam logic [14:0] RXB = 15'h2000;
  localparam logic [14:0] LK  = 15'h1000;
  localparam logic [14:0] TXR = 15'h0800;
  localparam logic [14:0] RXR = 15'h0400;
  localparam logic [14:0] SEQ = 15'h0300;
  localparam logic [14:0] LOS = 15'h00FF;
  localparam logic [14:0] ALL = 15'h7FFF;

  phyip_reset_responder #(
    .TX_CAL_CYCLES  (4),
    .RX_CAL_CYCLES  (3),
    .CDR_LOCK_CYCLES(5),
    .CNT_W          (16)
  ) dut (
    .clk               (clk),
    .tx_analogreset    (tx_analogreset),
    .rx_analogreset    (rx_analogreset),
    .tx_digitalreset   (tx_digitalreset),
    .rx_digitalreset   (rx_digitalreset),
    .rx_signal_detect  (rx_signal_detect),
    .tx_cal_busy       (tx_cal_busy),
    .rx_cal_busy       (rx_cal_busy),
    .rx_is_lockedtodata(rx_is_lockedtodata),
    .tx_phy_ready      (tx_phy_ready),
    .rx_phy_ready      (rx_phy_ready),
    .seq_error         (seq_error),
    .los_count         (los_count)
  );

  always #4 clk = ~clk;

  typedef struct {
    int          at;
    logic [14:0] mask;
    logic [14:0] val;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [14:0] pk(
    logic txb, logic rxb, logic lk,
    logic txr, logic rxr,
    logic [1:0] seq, int los);
    return {txb, rxb, lk, txr, rxr, seq, 8'(los)};
  endfunction

  task automatic chk(int dly, logic [14:0] mask,
                     logic [14:0] val, string tag);
    exp_t e;
    e.at   = cyc + dly;
    e.mask = mask;
    e.val  = val & mask;
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [14:0] obs;
  assign obs = {tx_cal_busy, rx_cal_busy, rx_is_lockedtodata,
                tx_phy_ready, rx_phy_ready, seq_error, los_count};

  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].at == cyc) begin
        total++;
        if ((obs & sbq[i].mask) === sbq[i].val)
          passed++;
        else
          $display("FAIL %s @cyc %0d: got %h want %h (mask %h)",
                   sbq[i].tag, cyc, obs & sbq[i].mask,
                   sbq[i].val, sbq[i].mask);
        sbq.delete(i);
      end
    end
  end

  initial begin
    step(2);
    chk(0, ALL, pk(1, 1, 0, 0, 0, 2'b00, 0), "reset_state");
    total++;
    if (tx_cal_busy === 1'b1) passed++;
    else $display("FAIL direct_tx_busy_rst");
    total++;
    if (rx_cal_busy === 1'b1) passed++;
    else $display("FAIL direct_rx_busy_rst");
    total++;
    if (rx_is_lockedtodata === 1'b0) passed++;
    else $display("FAIL direct_lock_rst");

    tx_analogreset = 1'b0;
    chk(3, TXB, TXB, "tx_busy_hold");
    chk(4, TXB, 0, "tx_busy_fall");
    chk(2, RXB, RXB, "rx_busy_hold");
    chk(3, RXB, 0, "rx_busy_fall");
    chk(7, LK, 0, "lock_not_yet");
    chk(8, LK, LK, "lock_rise");
    step(9);

    tx_digitalreset = 1'b0;
    rx_digitalreset = 1'b0;
    chk(0, TXR | RXR, 0, "ready_before");
    chk(1, TXR | RXR | SEQ,
        pk(0, 0, 0, 1, 1, 2'b00, 0), "ready_after");
    step(3);

    rx_signal_detect = 1'b0;
    chk(0, LK | RXR, LK | RXR, "run_before_los");
    chk(1, LK | RXR, 0, "los_drop");
    chk(5, LK, 0, "relock_not_yet");
    chk(6, LK | RXR, LK, "relock");
    chk(7, TXR | RXR | LOS,
        pk(0, 0, 0, 1, 1, 2'b00, LOS_EN), "rerun_loscnt");
    step(1);
    rx_signal_detect = 1'b1;
    step(7);

    rx_analogreset = 1'b1;
    chk(1, TXB | TXR | RXB | LK | RXR,
        pk(0, 1, 0, 1, 0, 2'b00, 0), "rxar_enter");
    chk(3, RXB, RXB, "rxar_busy_hold");
    chk(4, RXB | TXR, TXR, "rxar_busy_fall");
    chk(8, LK, 0, "rxar_lock_not_yet");
    chk(9, LK, LK, "rxar_relock");
    chk(10, RXR | LOS | SEQ,
        pk(0, 0, 0, 0, 1, 2'b00, LOS_EN), "rxar_run_loscnt");
    step(1);
    rx_analogreset = 1'b0;
    step(11);

    rx_digitalreset = 1'b1;
    chk(1, LOS, pk(0, 0, 0, 0, 0, 2'b00, 2 * LOS_EN),
        "chatter_loscnt");
    for (int k = 1; k <= 15; k++)
      chk(k, LK, 0, $sformatf("chatter_nolock_%0d", k));
    chk(13, SEQ, 0, "rx_seq_before");
    chk(14, SEQ, pk(0, 0, 0, 0, 0, 2'b10, 0), "rx_seq_set");
    for (int k = 0; k < 15; k++) begin
      rx_signal_detect = ((k / 3) % 2) == 1;
      if (k == 13) rx_digitalreset = 1'b0;
      step(1);
    end

    tx_analogreset   = 1'b1;
    tx_digitalreset  = 1'b1;
    rx_digitalreset  = 1'b1;
    rx_signal_detect = 1'b1;
    chk(0, ALL, pk(1, 1, 0, 0, 0, 2'b00, 0), "reassert_clear");
    step(2);
    tx_analogreset = 1'b0;
    chk(2, SEQ, 0, "tx_seq_before");
    chk(3, SEQ, pk(0, 0, 0, 0, 0, 2'b01, 0), "tx_seq_set");
    chk(8, SEQ, pk(0, 0, 0, 0, 0, 2'b01, 0), "tx_seq_sticky");
    chk(5, TXR, TXR, "tx_ready_late");
    step(2);
    tx_digitalreset = 1'b0;
    step(8);

    tx_digitalreset = 1'b1;
    tx_analogreset  = 1'b1;
    step(1);
    tx_analogreset = 1'b0;
    step(2);
    tx_analogreset = 1'b1;
    step(1);
    tx_analogreset = 1'b0;
    chk(0, TXB | SEQ, TXB, "midcal_restart");
    chk(3, TXB, TXB, "midcal_busy_hold");
    chk(4, TXB, 0, "midcal_busy_fall");
    step(8);
    total++;
    if (tx_cal_busy === 1'b0) passed++;
    else $display("FAIL direct_tx_busy_end");
    total++;
    if (tx_phy_ready === 1'b0) passed++;
    else $display("FAIL direct_tx_ready_end");

    @(negedge clk);
    #1;
    foreach (sbq[i]) begin
      total++;
      $display("FAIL %s: never compared (due cyc %0d, now %0d)",
               sbq[i].tag, sbq[i].at, cyc);
    end
    $display("%0d/%0d checks passed", passed, total);
    if (passed == total) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
